// File: rtl/elevator_call_panel_pkg.sv
// Shared encodings for the elevator call panel: per-floor call state and
// the FIFO write sequencer state.
package elevator_call_panel_pkg;

    // Lifecycle of one floor's call button.
    typedef enum logic [1:0] {
        FLOOR_IDLE    = 2'd0,
        FLOOR_PENDING = 2'd1,
        FLOOR_QUEUED  = 2'd2
    } floor_state_t;

    // FIFO write sequencer: one push, then a gap cycle before the next decision.
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PUSH = 2'd1,
        WR_GAP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/elevator_call_panel_call_sync.sv
// One call button: 2-flop synchroniser followed by a rising-edge detector.
// A button already held when reset releases is not reported until it has
// been seen released once, so a stuck or held button cannot fake a press.
module call_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_button,
    output logic o_press
);

    logic sync1;
    logic sync2;
    logic prev;
    logic fill1;
    logic fill2;
    logic arm;

    // Synchronise, remember last level, and arm only after a genuine low sample.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            arm   <= 1'b0;
        end else begin
            sync1 <= i_button;
            sync2 <= sync1;
            prev  <= sync2;
            fill1 <= 1'b1;
            fill2 <= fill1;
            if (fill2 && !sync2) begin
                arm <= 1'b1;
            end
        end
    end

    assign o_press = sync2 & ~prev & arm;

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: latches hall-call presses per floor, writes each new
// call into the request FIFO once (round-robin, at most one write per three
// cycles), and clears a floor's call when the door opens at that floor.
module elevator_call_panel
    import elevator_call_panel_pkg::*;
#(
    parameter int pFLOOR_WIDTH = 4,
    parameter int pNUM_FLOORS  = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [pNUM_FLOORS-1:0]  i_buttons,
    input  logic                    i_fifo_full,
    input  logic [pFLOOR_WIDTH-1:0] i_current_floor,
    input  logic                    i_open_door,
    output logic                    o_wr_en,
    output logic [pFLOOR_WIDTH-1:0] o_floor_no,
    output logic [pNUM_FLOORS-1:0]  o_call_lamps
);

    logic [pNUM_FLOORS-1:0]  press;
    floor_state_t            floor_q [pNUM_FLOORS];
    floor_state_t            floor_d [pNUM_FLOORS];
    logic [pNUM_FLOORS-1:0]  lamps_d;
    wr_state_t               wr_q;
    wr_state_t               wr_d;
    logic [pFLOOR_WIDTH-1:0] ptr_q;
    logic [pFLOOR_WIDTH-1:0] ptr_d;
    logic [pFLOOR_WIDTH-1:0] pick;
    logic                    pick_valid;
    logic                    push_go;
    logic                    full_q;
    logic                    door_q;
    logic                    door_prev_q;
    logic                    service;
    logic                    cur_in_range;

    for (genvar g = 0; g < pNUM_FLOORS; g++) begin : g_sync
        call_sync u_call_sync (
            .i_clock   (i_clock),
            .i_reset_n (i_reset_n),
            .i_button  (i_buttons[g]),
            .o_press   (press[g])
        );
    end

    // Service is the door opening, seen on the registered door signal.
    assign service      = door_q & ~door_prev_q;
    assign cur_in_range = int'(i_current_floor) < pNUM_FLOORS;
    assign push_go      = (wr_q == WR_IDLE) && pick_valid && !full_q;

    // Round-robin search for the first PENDING floor at or after the pointer.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < pNUM_FLOORS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= pNUM_FLOORS) begin
                idx = idx - pNUM_FLOORS;
            end
            if (!pick_valid && floor_q[idx] == FLOOR_PENDING) begin
                pick_valid = 1'b1;
                pick       = pFLOOR_WIDTH'(idx);
            end
        end
    end

    // Write sequencer next state and pointer update.
    always_comb begin
        wr_d  = wr_q;
        ptr_d = ptr_q;
        case (wr_q)
            WR_IDLE: begin
                if (push_go) begin
                    wr_d = WR_PUSH;
                    if (int'(pick) == pNUM_FLOORS - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = pick + pFLOOR_WIDTH'(1);
                    end
                end
            end
            WR_PUSH: wr_d = WR_GAP;
            WR_GAP:  wr_d = WR_IDLE;
            default: wr_d = WR_IDLE;
        endcase
    end

    // Per-floor next state: press, then queueing, then service (service wins).
    always_comb begin
        for (int f = 0; f < pNUM_FLOORS; f++) begin
            floor_d[f] = floor_q[f];
            if (press[f] && floor_q[f] == FLOOR_IDLE &&
                !(i_open_door && int'(i_current_floor) == f)) begin
                floor_d[f] = FLOOR_PENDING;
            end
            if (push_go && int'(pick) == f) begin
                floor_d[f] = FLOOR_QUEUED;
            end
            if (service && cur_in_range && int'(i_current_floor) == f) begin
                floor_d[f] = FLOOR_IDLE;
            end
            lamps_d[f] = (floor_d[f] != FLOOR_IDLE);
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int f = 0; f < pNUM_FLOORS; f++) begin
                floor_q[f] <= FLOOR_IDLE;
            end
            wr_q         <= WR_IDLE;
            ptr_q        <= '0;
            full_q       <= 1'b0;
            door_q       <= 1'b0;
            door_prev_q  <= 1'b0;
            o_wr_en      <= 1'b0;
            o_floor_no   <= '0;
            o_call_lamps <= '0;
        end else begin
            for (int f = 0; f < pNUM_FLOORS; f++) begin
                floor_q[f] <= floor_d[f];
            end
            wr_q         <= wr_d;
            ptr_q        <= ptr_d;
            full_q       <= i_fifo_full;
            door_q       <= i_open_door;
            door_prev_q  <= door_q;
            o_wr_en      <= (wr_d == WR_PUSH);
            if (push_go) begin
                o_floor_no <= pick;
            end
            o_call_lamps <= lamps_d;
        end
    end

endmodule

// File: doc/elevator_call_panel.md
ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

Interface
REQ-001 SHALL have parameter pFLOOR_WIDTH, default 4, the floor-number width.
REQ-002 SHALL have parameter pNUM_FLOORS, default 16, the number of call buttons (at most 2**pFLOOR_WIDTH).
REQ-003 SHALL have port i_clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_reset_n, input, 1, the reset, asynchronous and active-low.
REQ-005 SHALL have port i_buttons, input, pNUM_FLOORS, the raw asynchronous call buttons; bit f is floor f.
REQ-006 SHALL have port i_fifo_full, input, 1, the request FIFO full flag.
REQ-007 SHALL have port i_current_floor, input, pFLOOR_WIDTH, the car position.
REQ-008 SHALL have port i_open_door, input, 1, the door-open indication.
REQ-009 SHALL have port o_wr_en, output, 1, the single-cycle FIFO write strobe.
REQ-010 SHALL have port o_floor_no, output, pFLOOR_WIDTH, the floor written; valid only when o_wr_en=1.
REQ-011 SHALL have port o_call_lamps, output, pNUM_FLOORS, the per-floor "call registered" lamps.

Function
REQ-012 SHALL pass each i_buttons bit through a 2-flop synchroniser and then a rising-edge detector, so one press yields one press event, 3 cycles after the input edge.
REQ-013 SHALL keep a per-floor state: IDLE, PENDING (latched, not yet written), or QUEUED (written, awaiting service).
REQ-014 SHALL move a floor from IDLE to PENDING on a press event; a press while PENDING or QUEUED SHALL be ignored (no duplicate FIFO entries).
REQ-015 SHALL ignore a press for floor f when i_open_door=1 and i_current_floor=f in that cycle.
REQ-016 SHALL detect service as the rising edge of the registered i_open_door; floor i_current_floor then goes to IDLE from any state.
REQ-017 SHALL give service priority when service and a press event for the same floor occur in the same cycle; the result is IDLE.
REQ-018 SHALL run a write FSM with states IDLE, PUSH, and GAP.
REQ-019 SHALL have the write FSM leave IDLE for PUSH when any floor is PENDING and i_fifo_full=0.
REQ-020 SHALL hold o_wr_en=1 for exactly one cycle in PUSH, with the chosen floor on o_floor_no.
REQ-021 SHALL make that chosen floor QUEUED in the same cycle it is written.
REQ-022 SHALL go PUSH->GAP->IDLE unconditionally, so there is at most one write per 3 cycles and the registered full flag is always re-sampled.
REQ-023 SHALL select the floor by round-robin over PENDING floors, starting at the pointer.
REQ-024 SHALL advance the pointer to (chosen+1) mod pNUM_FLOORS after each write.
REQ-025 SHALL not write while i_fifo_full=1; PENDING floors wait, and lamps stay lit.
REQ-026 SHALL drive o_call_lamps[f]=1 while floor f is PENDING or QUEUED.
REQ-027 SHALL keep pending floors pending if i_current_floor is out of range (>= pNUM_FLOORS) on a service edge; that edge has no effect.
REQ-028 SHALL make all outputs registered.

Reset
REQ-029 SHALL, on asserted i_reset_n, at once clear these: o_wr_en=0, o_floor_no=0, o_call_lamps=0, every floor state to IDLE, the write FSM to IDLE, the pointer to 0, and the synchroniser/edge flops to 0.
REQ-030 SHALL let a write in progress at reset be lost, and SHALL not retry it after reset.
REQ-031 SHALL ignore a button held across reset release until it is released and pressed again.

Structure
REQ-032 SHALL put the floor-state encoding (IDLE/PENDING/QUEUED) and the write-FSM state encoding in the shared elevator package.
REQ-033 SHALL use one sub-module, call_sync, holding the per-bit 2-flop synchroniser and rising-edge detector, and SHALL instantiate it pNUM_FLOORS times.

Verification
REQ-034 SHALL verify a single call: a press on floor 5 -> o_call_lamps[5]=1 after 3 cycles; one o_wr_en pulse with o_floor_no=5; no further writes.
REQ-035 SHALL verify duplicates: floor 5 pressed 4 times before service -> exactly one write; the lamp clears at the open_door rise with current_floor=5.
REQ-036 SHALL verify round-robin: floors 2, 9, and 14 pressed in the same cycle with pointer 0 -> writes 2, 9, then 14, 3 cycles apart; the pointer ends at 15.
REQ-037 SHALL verify full backpressure: i_fifo_full=1 and floor 3 pressed -> no o_wr_en and lamp lit; full drops -> write of 3 within 2 cycles.
REQ-038 SHALL verify service with a press: door opens at floor 7 while floor 7 is pressed in the same cycle -> floor 7 IDLE, lamp 0, no write.
REQ-039 SHALL verify reset mid-operation: reset asserted during PUSH -> o_wr_en falls at once, lamps 0; after release with no presses, no writes.
